// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one full-adder cell plus carry FF, LSB first
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cy;
  logic [CW-1:0]    r_cnt;

  logic             w_h1_s;
  logic             w_h1_c;
  logic             w_h2_c;
  logic             w_s;
  logic             w_cy_next;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_next;

  // Full adder built from two half adders on the current LSBs and the carry FF.
  // The partial sum is kept in r_acc so the visible result only changes once
  // an operation completes.
  always_comb begin
    w_h1_s     = r_a[0] ^ r_b[0];
    w_h1_c     = r_a[0] & r_b[0];
    w_s        = w_h1_s ^ r_cy;
    w_h2_c     = w_h1_s & r_cy;
    w_cy_next  = w_h1_c | w_h2_c;
    w_last     = (r_cnt == CNT_LAST);
    w_acc_next = r_acc >> 1;
    w_acc_next[WIDTH-1] = w_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and handshake outputs, decoded from the current state.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand shift registers, carry FF, bit counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cy    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_cy  <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_acc <= w_acc_next;
          r_cy  <= w_cy_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum   <= w_acc_next;
            r_carry <= w_cy_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_sum   = r_sum;
  assign out_carry = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and sweep bench for serial_adder, WIDTH=8 and WIDTH=1
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_carry;

  logic       v1_in_valid;
  logic       v1_in_ready;
  logic [0:0] v1_in_a;
  logic [0:0] v1_in_b;
  logic       v1_out_valid;
  logic       v1_out_ready;
  logic [0:0] v1_out_sum;
  logic       v1_out_carry;

  int n_cmp;
  int n_err;

  serial_adder #(.WIDTH(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry)
  );

  serial_adder #(.WIDTH(1)) u_dut_w1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v1_in_valid),
    .in_ready  (v1_in_ready),
    .in_a      (v1_in_a),
    .in_b      (v1_in_b),
    .out_valid (v1_out_valid),
    .out_ready (v1_out_ready),
    .out_sum   (v1_out_sum),
    .out_carry (v1_out_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands for one cycle; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    check("in_ready_idle", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_run", {63'd0, in_ready}, 64'd0);
  endtask

  task automatic wait_result(input int already, input logic [8:0] exp);
    int n;
    n = already;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'd8);
    check("sum", {56'd0, out_sum}, {56'd0, exp[7:0]});
    check("carry", {63'd0, out_carry}, {63'd0, exp[8]});
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", {63'd0, out_valid}, 64'd0);
    check("in_ready_back", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic op1(input logic a, input logic b);
    int n;
    check("w1_in_ready", {63'd0, v1_in_ready}, 64'd1);
    v1_in_valid = 1'b1;
    v1_in_a     = a;
    v1_in_b     = b;
    @(negedge clk);
    v1_in_valid = 1'b0;
    n = 0;
    while (!v1_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w1_latency", 64'(n), 64'd1);
    check("w1_sum", {63'd0, v1_out_sum}, {63'd0, a ^ b});
    check("w1_carry", {63'd0, v1_out_carry}, {63'd0, a & b});
    v1_out_ready = 1'b1;
    @(negedge clk);
    v1_out_ready = 1'b0;
    check("w1_out_valid_drop", {63'd0, v1_out_valid}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    v1_in_valid = 1'b0;
    v1_in_a = '0;
    v1_in_b = '0;
    v1_out_ready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_sum", {56'd0, out_sum}, 64'd0);
    check("rst_out_carry", {63'd0, out_carry}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Out_ready asserted while idle has no effect.
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_out_ready", {63'd0, out_valid}, 64'd0);

    start_op(8'hFF, 8'h01); wait_result(0, 9'h100); release_result();
    start_op(8'hA5, 8'h5A); wait_result(0, 9'h0FF); release_result();
    start_op(8'h00, 8'h00); wait_result(0, 9'h000); release_result();
    start_op(8'h80, 8'h80); wait_result(0, 9'h100); release_result();

    // Hold the result without out_ready; a new in_valid must not be accepted.
    start_op(8'h12, 8'h34);
    wait_result(0, 9'h046);
    in_valid = 1'b1;
    in_a = 8'h77;
    in_b = 8'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_sum", {56'd0, out_sum}, 64'h46);
      check("hold_carry", {63'd0, out_carry}, 64'd0);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    release_result();

    // in_valid pulsed during RUN is ignored.
    start_op(8'h30, 8'h40);
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 8'h11;
    in_b = 8'h22;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(2, 9'h070);
    release_result();

    // Reset in the middle of RUN aborts immediately.
    start_op(8'h0F, 8'h0F);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_out_sum", {56'd0, out_sum}, 64'd0);
    check("abort_out_carry", {63'd0, out_carry}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_op(8'hC8, 8'h64); wait_result(0, 9'h12C); release_result();

    // WIDTH=1 instance, all operand combinations.
    op1(1'b0, 1'b0);
    op1(1'b0, 1'b1);
    op1(1'b1, 1'b0);
    op1(1'b1, 1'b1);

    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      start_op(ra, rb);
      wait_result(0, {1'b0, ra} + {1'b0, rb});
      release_result();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
